// File: rtl/noc_axi4_bridge_read_mo.sv
// Multi-outstanding NOC-to-AXI4 read bridge: up to OUTSTANDING AR bursts in flight,
// R beats reassembled into per-slot line buffers, responses retired in order or by completion.

`ifndef AXI4_DATA_WIDTH
`define AXI4_DATA_WIDTH 512
`endif
`ifndef AXI4_ADDR_WIDTH
`define AXI4_ADDR_WIDTH 64
`endif
`ifndef AXI4_ID_WIDTH
`define AXI4_ID_WIDTH 6
`endif
`ifndef AXI4_USER_WIDTH
`define AXI4_USER_WIDTH 11
`endif
`ifndef MSG_DATA_SIZE_WIDTH
`define MSG_DATA_SIZE_WIDTH 3
`endif

// One line buffer: tracks busy/done/err and assembles beats lane by lane.
module noc_axi4_bridge_read_mo_slot #(
  parameter int DWU    = 512,
  parameter int DW     = 512,
  parameter int IDW    = 6,
  parameter int BEAT_W = 1
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           alloc,
  input  logic [IDW-1:0] alloc_id,
  input  logic           free,
  input  logic           r_wr,
  input  logic [DWU-1:0] rdata,
  input  logic           r_err,
  input  logic           r_last,
  output logic           busy,
  output logic           done,
  output logic           err,
  output logic [IDW-1:0] id,
  output logic [DW-1:0]  data
);
  localparam int MAX_BURST = DW / DWU;

  logic [BEAT_W-1:0]              beat;
  logic [MAX_BURST-1:0][DWU-1:0]  buf_q;
  logic                           take;

  // beats to idle or already-completed slots are stale and dropped
  assign take = r_wr && busy && !done;
  assign data = buf_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy <= 1'b0;
      done <= 1'b0;
      err  <= 1'b0;
      beat <= '0;
      id   <= '0;
    end else if (alloc) begin
      busy <= 1'b1;
      done <= 1'b0;
      err  <= 1'b0;
      beat <= '0;
      id   <= alloc_id;
    end else if (free) begin
      busy <= 1'b0;
      done <= 1'b0;
    end else if (take) begin
      err <= err | r_err;
      if (r_last) begin
        done <= 1'b1;
        beat <= '0;
      end else begin
        beat <= beat + BEAT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buf_q <= '0;
    end else begin
      for (int b = 0; b < MAX_BURST; b++)
        if (take && beat == BEAT_W'(b)) buf_q[b] <= rdata;
    end
  end
endmodule

module noc_axi4_bridge_read_mo #(
  parameter int AXI4_DAT_WIDTH_USED = `AXI4_DATA_WIDTH,
  parameter int OUTSTANDING         = 4,
  parameter int IN_ORDER            = 1
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              req_val,
  output logic                              req_rdy,
  input  logic [`AXI4_ADDR_WIDTH-1:0]       req_addr,
  input  logic [`MSG_DATA_SIZE_WIDTH-1:0]   req_size_log,
  input  logic [`AXI4_ID_WIDTH-1:0]         req_id,
  output logic                              resp_val,
  input  logic                              resp_rdy,
  output logic [`AXI4_ID_WIDTH-1:0]         resp_id,
  output logic [`AXI4_DATA_WIDTH-1:0]       resp_data,
  output logic                              resp_err,
  output logic [`AXI4_ID_WIDTH-1:0]         m_axi_arid,
  output logic [`AXI4_ADDR_WIDTH-1:0]       m_axi_araddr,
  output logic [7:0]                        m_axi_arlen,
  output logic [2:0]                        m_axi_arsize,
  output logic [1:0]                        m_axi_arburst,
  output logic                              m_axi_arlock,
  output logic [3:0]                        m_axi_arcache,
  output logic [2:0]                        m_axi_arprot,
  output logic [3:0]                        m_axi_arqos,
  output logic [3:0]                        m_axi_arregion,
  output logic [`AXI4_USER_WIDTH-1:0]       m_axi_aruser,
  output logic                              m_axi_arvalid,
  input  logic                              m_axi_arready,
  input  logic [`AXI4_ID_WIDTH-1:0]         m_axi_rid,
  input  logic [AXI4_DAT_WIDTH_USED-1:0]    m_axi_rdata,
  input  logic [1:0]                        m_axi_rresp,
  input  logic                              m_axi_rlast,
  input  logic [`AXI4_USER_WIDTH-1:0]       m_axi_ruser,
  input  logic                              m_axi_rvalid,
  output logic                              m_axi_rready
);
  localparam int DW        = `AXI4_DATA_WIDTH;
  localparam int AW        = `AXI4_ADDR_WIDTH;
  localparam int IDW       = `AXI4_ID_WIDTH;
  localparam int DWU       = AXI4_DAT_WIDTH_USED;
  localparam int SLOT_W    = (OUTSTANDING > 1) ? $clog2(OUTSTANDING) : 1;
  localparam int CNT_W     = $clog2(OUTSTANDING) + 1;
  localparam int MAX_BURST = DW / DWU;
  localparam int BEAT_W    = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
  localparam int DWU_LOG   = $clog2(DWU / 8);

  typedef struct packed {
    logic [AW-1:0]     addr;
    logic [7:0]        len;
    logic [2:0]        size;
    logic [SLOT_W-1:0] slot;
  } ar_req_t;

  typedef struct packed {
    logic [IDW-1:0] id;
    logic           err;
    logic [DW-1:0]  data;
  } resp_t;

  logic [OUTSTANDING-1:0]           busy, done, alloc, free, r_hit, slot_err;
  logic [OUTSTANDING-1:0][IDW-1:0]  slot_id;
  logic [OUTSTANDING-1:0][DW-1:0]   slot_data;
  logic [SLOT_W-1:0]                alloc_ptr, ret_ptr, alloc_slot, ret_slot, r_slot;
  logic [CNT_W-1:0]                 count;
  logic                             ar_pend, req_go, resp_go;
  ar_req_t                          ar_q, ar_d;
  resp_t                            ret;
  int                               bll;

  always_comb begin
    alloc_slot = alloc_ptr;
    ret_slot   = ret_ptr;
    if (IN_ORDER == 0) begin
      alloc_slot = '0;
      ret_slot   = '0;
      for (int i = OUTSTANDING - 1; i >= 0; i--) begin
        if (!busy[i])           alloc_slot = SLOT_W'(i);
        if (busy[i] && done[i]) ret_slot   = SLOT_W'(i);
      end
    end
  end

  assign req_rdy  = (count < CNT_W'(OUTSTANDING)) && (!ar_pend || m_axi_arready);
  assign req_go   = req_val && req_rdy;
  assign resp_val = busy[ret_slot] && done[ret_slot];
  assign resp_go  = resp_val && resp_rdy;
  assign r_slot   = m_axi_rid[SLOT_W-1:0];

  // negative beat-length log means a narrow single-beat transfer
  always_comb begin
    bll        = int'(req_size_log) - DWU_LOG;
    ar_d.addr  = req_addr;
    ar_d.slot  = alloc_slot;
    if (bll >= 0) begin
      ar_d.len  = 8'((1 << bll) - 1);
      ar_d.size = 3'(DWU_LOG);
    end else begin
      ar_d.len  = 8'd0;
      ar_d.size = 3'(req_size_log);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ar_pend   <= 1'b0;
      ar_q      <= '0;
      alloc_ptr <= '0;
      ret_ptr   <= '0;
      count     <= '0;
    end else begin
      if (req_go) begin
        ar_pend   <= 1'b1;
        ar_q      <= ar_d;
        alloc_ptr <= alloc_ptr + SLOT_W'(1);
      end else if (m_axi_arready) begin
        ar_pend <= 1'b0;
      end
      if (resp_go) ret_ptr <= ret_ptr + SLOT_W'(1);
      case ({req_go, resp_go})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  always_comb begin
    for (int i = 0; i < OUTSTANDING; i++) begin
      alloc[i] = req_go && (alloc_slot == SLOT_W'(i));
      free[i]  = resp_go && (ret_slot == SLOT_W'(i));
      r_hit[i] = m_axi_rvalid && (r_slot == SLOT_W'(i));
    end
  end

  for (genvar g = 0; g < OUTSTANDING; g++) begin : g_slot
    noc_axi4_bridge_read_mo_slot #(
      .DWU(DWU), .DW(DW), .IDW(IDW), .BEAT_W(BEAT_W)
    ) u_slot (
      .clk     (clk),
      .rst_n   (rst_n),
      .alloc   (alloc[g]),
      .alloc_id(req_id),
      .free    (free[g]),
      .r_wr    (r_hit[g]),
      .rdata   (m_axi_rdata),
      .r_err   (m_axi_rresp[1]),
      .r_last  (m_axi_rlast),
      .busy    (busy[g]),
      .done    (done[g]),
      .err     (slot_err[g]),
      .id      (slot_id[g]),
      .data    (slot_data[g])
    );
  end

  always_comb begin
    ret = '0;
    if (resp_val) begin
      ret.id   = slot_id[ret_slot];
      ret.err  = slot_err[ret_slot];
      ret.data = slot_data[ret_slot];
    end
  end

  assign resp_id   = ret.id;
  assign resp_err  = ret.err;
  assign resp_data = ret.data;

  assign m_axi_arvalid  = ar_pend;
  assign m_axi_arid     = IDW'(ar_q.slot);
  assign m_axi_araddr   = ar_q.addr;
  assign m_axi_arlen    = ar_q.len;
  assign m_axi_arsize   = ar_q.size;
  assign m_axi_arburst  = 2'b01;
  assign m_axi_arlock   = 1'b0;
  assign m_axi_arcache  = 4'b0011;
  assign m_axi_arprot   = 3'b000;
  assign m_axi_arqos    = 4'b0000;
  assign m_axi_arregion = 4'b0000;
  assign m_axi_aruser   = '0;
  assign m_axi_rready   = 1'b1;

  logic unused_r;
  assign unused_r = ^{m_axi_ruser, m_axi_rid[IDW-1:SLOT_W], m_axi_rresp[0]};
endmodule

// File: tb/tb_noc_axi4_bridge_read_mo.sv
// Directed bench: in-order 512-bit bridge (dut 0) and completion-order 64-bit bridge (dut 1).

`ifndef AXI4_DATA_WIDTH
`define AXI4_DATA_WIDTH 512
`endif
`ifndef AXI4_ADDR_WIDTH
`define AXI4_ADDR_WIDTH 64
`endif
`ifndef AXI4_ID_WIDTH
`define AXI4_ID_WIDTH 6
`endif
`ifndef AXI4_USER_WIDTH
`define AXI4_USER_WIDTH 11
`endif
`ifndef MSG_DATA_SIZE_WIDTH
`define MSG_DATA_SIZE_WIDTH 3
`endif

module tb_noc_axi4_bridge_read_mo;
  localparam int AW = `AXI4_ADDR_WIDTH;
  localparam int IW = `AXI4_ID_WIDTH;
  localparam int DW = `AXI4_DATA_WIDTH;
  localparam int SW = `MSG_DATA_SIZE_WIDTH;
  localparam int UW = `AXI4_USER_WIDTH;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          req_val[2], req_rdy[2], resp_val[2], resp_rdy[2], resp_err[2];
  logic          arvalid[2], arready[2], arlock[2], rvalid[2], rlast[2], rready[2];
  logic [AW-1:0] req_addr[2], araddr[2];
  logic [SW-1:0] req_size_log[2];
  logic [IW-1:0] req_id[2], resp_id[2], arid[2], rid[2];
  logic [DW-1:0] resp_data[2], rdata[2];
  logic [7:0]    arlen[2];
  logic [2:0]    arsize[2], arprot[2];
  logic [1:0]    arburst[2], rresp[2];
  logic [3:0]    arcache[2], arqos[2], arregion[2];
  logic [UW-1:0] aruser[2], ruser[2];

  int total = 0;
  int bad = 0;

  noc_axi4_bridge_read_mo #(.AXI4_DAT_WIDTH_USED(512), .OUTSTANDING(4), .IN_ORDER(1)) dut0 (
    .clk(clk), .rst_n(rst_n),
    .req_val(req_val[0]), .req_rdy(req_rdy[0]), .req_addr(req_addr[0]),
    .req_size_log(req_size_log[0]), .req_id(req_id[0]),
    .resp_val(resp_val[0]), .resp_rdy(resp_rdy[0]), .resp_id(resp_id[0]),
    .resp_data(resp_data[0]), .resp_err(resp_err[0]),
    .m_axi_arid(arid[0]), .m_axi_araddr(araddr[0]), .m_axi_arlen(arlen[0]),
    .m_axi_arsize(arsize[0]), .m_axi_arburst(arburst[0]), .m_axi_arlock(arlock[0]),
    .m_axi_arcache(arcache[0]), .m_axi_arprot(arprot[0]), .m_axi_arqos(arqos[0]),
    .m_axi_arregion(arregion[0]), .m_axi_aruser(aruser[0]), .m_axi_arvalid(arvalid[0]),
    .m_axi_arready(arready[0]),
    .m_axi_rid(rid[0]), .m_axi_rdata(rdata[0]), .m_axi_rresp(rresp[0]),
    .m_axi_rlast(rlast[0]), .m_axi_ruser(ruser[0]), .m_axi_rvalid(rvalid[0]),
    .m_axi_rready(rready[0])
  );

  noc_axi4_bridge_read_mo #(.AXI4_DAT_WIDTH_USED(64), .OUTSTANDING(4), .IN_ORDER(0)) dut1 (
    .clk(clk), .rst_n(rst_n),
    .req_val(req_val[1]), .req_rdy(req_rdy[1]), .req_addr(req_addr[1]),
    .req_size_log(req_size_log[1]), .req_id(req_id[1]),
    .resp_val(resp_val[1]), .resp_rdy(resp_rdy[1]), .resp_id(resp_id[1]),
    .resp_data(resp_data[1]), .resp_err(resp_err[1]),
    .m_axi_arid(arid[1]), .m_axi_araddr(araddr[1]), .m_axi_arlen(arlen[1]),
    .m_axi_arsize(arsize[1]), .m_axi_arburst(arburst[1]), .m_axi_arlock(arlock[1]),
    .m_axi_arcache(arcache[1]), .m_axi_arprot(arprot[1]), .m_axi_arqos(arqos[1]),
    .m_axi_arregion(arregion[1]), .m_axi_aruser(aruser[1]), .m_axi_arvalid(arvalid[1]),
    .m_axi_arready(arready[1]),
    .m_axi_rid(rid[1]), .m_axi_rdata(rdata[1][63:0]), .m_axi_rresp(rresp[1]),
    .m_axi_rlast(rlast[1]), .m_axi_ruser(ruser[1]), .m_axi_rvalid(rvalid[1]),
    .m_axi_rready(rready[1])
  );

  function automatic logic [DW-1:0] pat(input int k);
    return {16{32'hA500_0000 | 32'(k)}};
  endfunction

  // stimulus helpers: all start and end on a falling edge
  task automatic send_req(input int d, input logic [AW-1:0] a, input logic [SW-1:0] s,
                          input logic [IW-1:0] id);
    bit ok = 1'b0;
    req_val[d] = 1'b1; req_addr[d] = a; req_size_log[d] = s; req_id[d] = id;
    for (int t = 0; t < 20 && !ok; t++) begin
      ok = req_rdy[d];
      @(negedge clk);
    end
    req_val[d] = 1'b0;
    if (!ok) begin
      total++; bad++;
      $display("FAIL req_accept dut%0d id=%0d: req_rdy stayed 0, required 1", d, id);
    end
  endtask

  task automatic r_beat(input int d, input logic [IW-1:0] id, input logic [DW-1:0] data,
                        input logic [1:0] resp, input logic last);
    rvalid[d] = 1'b1; rid[d] = id; rdata[d] = data; rresp[d] = resp; rlast[d] = last;
    @(negedge clk);
    rvalid[d] = 1'b0; rlast[d] = 1'b0; rresp[d] = 2'b00;
  endtask

  task automatic wait_resp(input int d);
    bit ok = 1'b0;
    for (int t = 0; t < 20 && !ok; t++) begin
      ok = resp_val[d];
      if (!ok) @(negedge clk);
    end
    if (!ok) begin
      total++; bad++;
      $display("FAIL resp_timeout dut%0d: resp_val stayed 0, required 1", d);
    end
  endtask

  task automatic pop(input int d);
    resp_rdy[d] = 1'b1;
    @(negedge clk);
    resp_rdy[d] = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      total++;
      if (arvalid[d] !== 1'b0 || resp_val[d] !== 1'b0 || req_rdy[d] !== 1'b1)
        begin bad++; $display("FAIL reset_ctl dut%0d: arvalid=%b resp_val=%b req_rdy=%b, required 0 0 1",
                              d, arvalid[d], resp_val[d], req_rdy[d]); end
      total++;
      if (resp_id[d] !== '0 || resp_data[d] !== '0 || resp_err[d] !== 1'b0)
        begin bad++; $display("FAIL reset_resp dut%0d: id=%0h err=%b data=%h, required 0", d,
                              resp_id[d], resp_err[d], resp_data[d]); end
      total++;
      if (arid[d] !== '0 || araddr[d] !== '0 || arlen[d] !== 8'd0 || arsize[d] !== 3'd0 || rready[d] !== 1'b1)
        begin bad++; $display("FAIL reset_ar dut%0d: arid=%0h araddr=%0h arlen=%0d arsize=%0d rready=%b, required 0 0 0 0 1",
                              d, arid[d], araddr[d], arlen[d], arsize[d], rready[d]); end
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_in_order();
    for (int i = 0; i < 4; i++) begin
      send_req(0, AW'(64'h1000 + 64 * i), 3'd6, IW'(5 + i));
      total++;
      if (arvalid[0] !== 1'b1 || arid[0] !== IW'(i) || arlen[0] !== 8'd0 || arsize[0] !== 3'd6 ||
          araddr[0] !== AW'(64'h1000 + 64 * i))
        begin bad++; $display("FAIL io_ar%0d: arvalid=%b arid=%0d arlen=%0d arsize=%0d araddr=%0h, required 1 %0d 0 6 %0h",
                              i, arvalid[0], arid[0], arlen[0], arsize[0], araddr[0], i, 64'h1000 + 64 * i); end
    end
    total++;
    if (arburst[0] !== 2'b01 || arcache[0] !== 4'b0011 || arlock[0] !== 1'b0 || arprot[0] !== 3'd0)
      begin bad++; $display("FAIL ar_const: arburst=%b arcache=%b arlock=%b arprot=%0d, required 01 0011 0 0",
                            arburst[0], arcache[0], arlock[0], arprot[0]); end
    req_val[0] = 1'b1; req_id[0] = 6'd9; req_addr[0] = 64'h2000; req_size_log[0] = 3'd6;
    total++;
    if (req_rdy[0] !== 1'b0) begin bad++; $display("FAIL full_rdy: req_rdy=%b, required 0", req_rdy[0]); end
    r_beat(0, 6'd2, pat(2), 2'b00, 1'b1);
    total++;
    if (resp_val[0] !== 1'b0) begin bad++; $display("FAIL io_hold_slot2: resp_val=%b, required 0", resp_val[0]); end
    r_beat(0, 6'd0, pat(0), 2'b00, 1'b1);
    r_beat(0, 6'd3, pat(3), 2'b00, 1'b1);
    r_beat(0, 6'd1, pat(1), 2'b00, 1'b1);
    for (int k = 0; k < 4; k++) begin
      total++;
      if (resp_val[0] !== 1'b1 || resp_id[0] !== IW'(5 + k) || resp_data[0] !== pat(k) || resp_err[0] !== 1'b0)
        begin bad++; $display("FAIL io_resp%0d: val=%b id=%0d err=%b data=%h, required 1 %0d 0 %h",
                              k, resp_val[0], resp_id[0], resp_err[0], resp_data[0], 5 + k, pat(k)); end
      if (k == 0) begin
        total++;
        if (req_rdy[0] !== 1'b0) begin bad++; $display("FAIL full_rdy_pre_ret: req_rdy=%b, required 0", req_rdy[0]); end
      end
      pop(0);
      if (k == 0) begin
        total++;
        if (req_rdy[0] !== 1'b1) begin bad++; $display("FAIL rdy_after_ret: req_rdy=%b, required 1", req_rdy[0]); end
      end
      if (k == 1) begin
        req_val[0] = 1'b0;
        total++;
        if (arvalid[0] !== 1'b1 || arid[0] !== 6'd0)
          begin bad++; $display("FAIL io_realloc: arvalid=%b arid=%0d, required 1 0", arvalid[0], arid[0]); end
      end
    end
    r_beat(0, 6'd0, pat(9), 2'b00, 1'b1);
    wait_resp(0);
    total++;
    if (resp_id[0] !== 6'd9 || resp_data[0] !== pat(9))
      begin bad++; $display("FAIL io_wrap_resp: id=%0d data=%h, required 9 %h", resp_id[0], resp_data[0], pat(9)); end
    pop(0);
  endtask

  task automatic test_out_of_order();
    int order[4] = '{2, 0, 3, 1};
    int exp_id[4] = '{7, 5, 8, 6};
    for (int i = 0; i < 4; i++) begin
      send_req(1, AW'(64'h3000 + 8 * i), 3'd3, IW'(5 + i));
      total++;
      if (arid[1] !== IW'(i) || arlen[1] !== 8'd0 || arsize[1] !== 3'd3)
        begin bad++; $display("FAIL ooo_ar%0d: arid=%0d arlen=%0d arsize=%0d, required %0d 0 3",
                              i, arid[1], arlen[1], arsize[1], i); end
    end
    for (int j = 0; j < 4; j++) begin
      r_beat(1, IW'(order[j]), DW'(64'h100 + order[j]), 2'b00, 1'b1);
      total++;
      if (resp_val[1] !== 1'b1 || resp_id[1] !== IW'(exp_id[j]) || resp_data[1][63:0] !== 64'h100 + 64'(order[j]))
        begin bad++; $display("FAIL ooo_resp%0d: val=%b id=%0d data=%0h, required 1 %0d %0h",
                              j, resp_val[1], resp_id[1], resp_data[1][63:0], exp_id[j], 64'h100 + order[j]); end
      pop(1);
    end
    send_req(1, 64'h3100, 3'd3, 6'd20);
    send_req(1, 64'h3108, 3'd3, 6'd21);
    r_beat(1, 6'd1, DW'(64'h21), 2'b00, 1'b1);
    r_beat(1, 6'd0, DW'(64'h20), 2'b00, 1'b1);
    total++;
    if (resp_id[1] !== 6'd20) begin bad++; $display("FAIL ooo_lowest_first: id=%0d, required 20", resp_id[1]); end
    pop(1);
    total++;
    if (resp_val[1] !== 1'b1 || resp_id[1] !== 6'd21)
      begin bad++; $display("FAIL ooo_lowest_next: val=%b id=%0d, required 1 21", resp_val[1], resp_id[1]); end
    pop(1);
  endtask

  task automatic test_downsize();
    logic [DW-1:0] exp_line = '0;
    send_req(1, 64'h4000, 3'd6, 6'd10);
    total++;
    if (arid[1] !== 6'd0 || arlen[1] !== 8'd7 || arsize[1] !== 3'd3)
      begin bad++; $display("FAIL ds_ar: arid=%0d arlen=%0d arsize=%0d, required 0 7 3", arid[1], arlen[1], arsize[1]); end
    for (int i = 0; i < 8; i++) begin
      exp_line[64 * i +: 64] = 64'(i);
      r_beat(1, 6'd0, DW'(i), (i == 3) ? 2'b10 : 2'b00, i == 7);
      if (i == 6) begin
        total++;
        if (resp_val[1] !== 1'b0) begin bad++; $display("FAIL ds_early_val: resp_val=%b, required 0", resp_val[1]); end
      end
    end
    wait_resp(1);
    total++;
    if (resp_id[1] !== 6'd10 || resp_err[1] !== 1'b1 || resp_data[1] !== exp_line)
      begin bad++; $display("FAIL ds_line: id=%0d err=%b data=%h, required 10 1 %h",
                            resp_id[1], resp_err[1], resp_data[1], exp_line); end
    pop(1);
    send_req(1, 64'h5000, 3'd2, 6'd11);
    total++;
    if (arlen[1] !== 8'd0 || arsize[1] !== 3'd2)
      begin bad++; $display("FAIL narrow_ar: arlen=%0d arsize=%0d, required 0 2", arlen[1], arsize[1]); end
    r_beat(1, 6'd0, DW'(64'hDEAD_BEEF), 2'b00, 1'b1);
    total++;
    if (resp_id[1] !== 6'd11 || resp_err[1] !== 1'b0 || resp_data[1][63:0] !== 64'hDEAD_BEEF)
      begin bad++; $display("FAIL narrow_resp: id=%0d err=%b data=%0h, required 11 0 deadbeef",
                            resp_id[1], resp_err[1], resp_data[1][63:0]); end
    pop(1);
  endtask

  task automatic test_back_to_back();
    req_val[1] = 1'b1; req_addr[1] = 64'h9000; req_size_log[1] = 3'd3;
    for (int i = 0; i < 3; i++) begin
      req_id[1] = IW'(30 + i);
      total++;
      if (req_rdy[1] !== 1'b1) begin bad++; $display("FAIL b2b_rdy%0d: req_rdy=%b, required 1", i, req_rdy[1]); end
      @(negedge clk);
      total++;
      if (arvalid[1] !== 1'b1 || arid[1] !== IW'(i))
        begin bad++; $display("FAIL b2b_ar%0d: arvalid=%b arid=%0d, required 1 %0d", i, arvalid[1], arid[1], i); end
    end
    req_val[1] = 1'b0;
    for (int i = 2; i >= 0; i--) r_beat(1, IW'(i), DW'(i), 2'b00, 1'b1);
    for (int i = 0; i < 3; i++) begin
      total++;
      if (resp_val[1] !== 1'b1 || resp_id[1] !== IW'(30 + i))
        begin bad++; $display("FAIL b2b_ret%0d: val=%b id=%0d, required 1 %0d", i, resp_val[1], resp_id[1], 30 + i); end
      pop(1);
    end
  endtask

  task automatic test_ar_hold();
    arready[1] = 1'b0;
    send_req(1, 64'h6000, 3'd3, 6'd40);
    repeat (3) @(negedge clk);
    total++;
    if (arvalid[1] !== 1'b1 || arid[1] !== 6'd0 || araddr[1] !== 64'h6000 || req_rdy[1] !== 1'b0)
      begin bad++; $display("FAIL ar_hold: arvalid=%b arid=%0d araddr=%0h req_rdy=%b, required 1 0 6000 0",
                            arvalid[1], arid[1], araddr[1], req_rdy[1]); end
    arready[1] = 1'b1;
    @(negedge clk);
    total++;
    if (arvalid[1] !== 1'b0) begin bad++; $display("FAIL ar_release: arvalid=%b, required 0", arvalid[1]); end
    r_beat(1, 6'd0, DW'(64'h40), 2'b00, 1'b1);
    total++;
    if (resp_id[1] !== 6'd40) begin bad++; $display("FAIL ar_hold_resp: id=%0d, required 40", resp_id[1]); end
    pop(1);
  endtask

  task automatic test_reset_mid();
    send_req(0, 64'h7000, 3'd6, 6'd1);
    send_req(0, 64'h7040, 3'd6, 6'd2);
    arready[0] = 1'b0;
    r_beat(0, 6'd1, pat(1), 2'b00, 1'b1);
    rst_n = 1'b0;
    #1;
    total++;
    if (arvalid[0] !== 1'b0 || resp_val[0] !== 1'b0 || arid[0] !== '0)
      begin bad++; $display("FAIL mid_reset: arvalid=%b resp_val=%b arid=%0d, required 0 0 0",
                            arvalid[0], resp_val[0], arid[0]); end
    @(negedge clk);
    rst_n = 1'b1;
    arready[0] = 1'b1;
    r_beat(0, 6'd2, pat(2), 2'b10, 1'b1);
    total++;
    if (resp_val[0] !== 1'b0) begin bad++; $display("FAIL late_rlast: resp_val=%b, required 0", resp_val[0]); end
    send_req(0, 64'h8000, 3'd6, 6'd3);
    total++;
    if (arid[0] !== 6'd0) begin bad++; $display("FAIL post_reset_arid: arid=%0d, required 0", arid[0]); end
    r_beat(0, 6'd0, pat(3), 2'b00, 1'b1);
    total++;
    if (resp_val[0] !== 1'b1 || resp_id[0] !== 6'd3 || resp_err[0] !== 1'b0)
      begin bad++; $display("FAIL post_reset_resp: val=%b id=%0d err=%b, required 1 3 0",
                            resp_val[0], resp_id[0], resp_err[0]); end
    pop(0);
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      req_val[d] = 1'b0; req_addr[d] = '0; req_size_log[d] = '0; req_id[d] = '0;
      resp_rdy[d] = 1'b0; arready[d] = 1'b1; rvalid[d] = 1'b0; rid[d] = '0;
      rdata[d] = '0; rresp[d] = 2'b00; rlast[d] = 1'b0; ruser[d] = '0;
    end
    test_reset();
    test_in_order();
    test_out_of_order();
    test_downsize();
    test_back_to_back();
    test_ar_hold();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required finish");
    $fatal(1);
  end
endmodule

// File: doc/noc_axi4_bridge_read_mo.md
# noc_axi4_bridge_read_mo

Multi-outstanding successor to the single-request NOC-to-AXI4 read bridge. It accepts NOC read requests, issues up to OUTSTANDING concurrent AXI4 AR bursts tagged by slot index, and reassembles (possibly down-converted) R beats into per-slot line buffers. It returns full-line responses to the NOC side either in request order or in completion order, with a per-response error flag. It sits in the chipset NOC-AXI4 bridge between the request deserializer and the AXI interconnect.

## Interface
- AXI4_DAT_WIDTH_USED, `AXI4_DATA_WIDTH: actual R data width; `AXI4_DATA_WIDTH / AXI4_DAT_WIDTH_USED is a power of 2.
- OUTSTANDING, 4: number of slots; a power of 2, ≤ 2^`AXI4_ID_WIDTH.
- IN_ORDER, 1: 1 = retire in request order; 0 = retire lowest-index completed slot.

Ports:
- clk  in  1  sole clock
- rst_n  in  1  reset; asynchronous, active-low
- req_val / req_rdy  in / out  1  NOC request handshake
- req_addr  in  `AXI4_ADDR_WIDTH  byte address
- req_size_log  in  `MSG_DATA_SIZE_WIDTH  log2 of request bytes
- req_id  in  `AXI4_ID_WIDTH  NOC tag, returned on resp_id
- resp_val / resp_rdy  out / in  1  response handshake
- resp_id  out  `AXI4_ID_WIDTH  tag of retiring request
- resp_data  out  `AXI4_DATA_WIDTH  assembled line
- resp_err  out  1  OR of rresp[1] over all beats of the burst
- m_axi_ar*: arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arqos, arregion, aruser, arvalid out; arready in (standard AXI4 widths)
- m_axi_r*: rid, rdata (AXI4_DAT_WIDTH_USED), rresp, rlast, ruser, rvalid in; rready out

## Operation
- Constants: arburst=INCR (01), arlock=0, arcache=0011, arprot/arqos/arregion/aruser=0.
- Slot state per entry: busy, done, err, req_id, beat counter (log2(MAX_BURST) bits, MAX_BURST = `AXI4_DATA_WIDTH/AXI4_DAT_WIDTH_USED), data buffer.
- Allocation: IN_ORDER=1 uses circular alloc_ptr; IN_ORDER=0 uses lowest-index non-busy slot. count tracks busy slots.
- AR stage: one register (ar_pend, addr, size_log, slot). req_rdy = (count < OUTSTANDING) && (!ar_pend || m_axi_arready). On req_go: slot marked busy, done=0, err=0, beat=0, req_id stored, AR register loaded.
- arid = slot index zero-extended; araddr = stored addr.
- bll = signed(size_log) − log2(AXI4_DAT_WIDTH_USED/8); arlen = (1 << max(bll,0)) − 1; arsize = bll<0 ? size_log : log2(AXI4_DAT_WIDTH_USED/8).
- R: m_axi_rready = 1 constantly (buffers are pre-allocated). Slot = rid low log2(OUTSTANDING) bits; upper rid bits ignored. Beat written at bit offset beat×AXI4_DAT_WIDTH_USED; beat++; err |= rresp[1]; rlast sets done and clears the counter. Beats to a non-busy slot, or to an already-done slot, are discarded without state change.
- Retire candidate: IN_ORDER=1 is ret_ptr's slot; IN_ORDER=0 is the lowest-index done slot. resp_val = candidate busy&done. resp_id/resp_data/resp_err are muxed from that slot, stable while resp_val=1 and resp_rdy=0. resp_go clears busy/done and advances ret_ptr.
- Simultaneous req_go and resp_go: count unchanged. A slot freed this cycle is allocatable next cycle, not the same cycle.
- Reset (any time, mid-burst included): all slots free, pointers/count 0, ar_pend=0; outputs arvalid=0, resp_val=0, resp_id=0, resp_data=0, resp_err=0, arid/araddr/arlen/arsize=0, rready=1 after release. In-flight AXI responses returning after reset are discarded by the non-busy rule.

## Timing
- req_go at cycle N → arvalid at N+1; AR payload held until arready.
- Back-to-back requests: one per cycle while arready=1 and slots remain.
- Last R beat at cycle M → resp_val at M+1 if the slot is the retire candidate.
- Retirement: one per cycle; after resp_go at cycle K, next candidate visible at K+1.
- Full: count=OUTSTANDING forces req_rdy=0 until a resp_go occurs.

## Test plan
- OUTSTANDING=4, IN_ORDER=1, 512/512: 4 requests (ids 5,6,7,8, size_log 6) → arid 0..3, arlen 0, arsize 6; 5th request sees req_rdy=0 until first resp_go.
- Same config, R returns rid 2,0,3,1 → responses ids 5,6,7,8 in order; slot 2 data is held until slot 0 and 1 retire.
- IN_ORDER=0, same R order → responses ids 7,5,8,6.
- AXI4_DAT_WIDTH_USED=64, size_log 6 → arlen 7, arsize 3; 8 beats 0x0..0x7 → resp_data has beat i at bits [64i+63:64i]. Size_log 2 → arlen 0, arsize 2.
- Beat 3 with rresp=2'b10 → resp_err=1 for that response only; next response resp_err=0.
- rst_n low mid-burst with 2 slots busy → resp_val=0, arvalid=0 immediately; late rlast for old rid is ignored; a new request after reset gets arid 0.
